mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares the multi-cycle RISC-V core's single unified instruction/data memory port with a debug/program loader. It sits between the core's memory interface (address mux output, memWrite, write data) and the memory. It serialises accesses with round-robin priority, an optional debug lock and a per-transaction timeout. The core stalls its state machine on `c_req & ~c_ack`.

---
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between the core and a debug loader,
// with a debug lock that blocks core grants and a per-access timeout.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_ack,
  output logic              c_err,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_lock,
  output logic              d_ack,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic              busy,
  output logic              owner
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CORE = 2'd1,
    DBG  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_last_owner;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_m_we;
  logic [ADDR_W-1:0] r_m_addr;
  logic [DATA_W-1:0] r_m_wdata;
  logic              r_c_ack;
  logic              r_c_err;
  logic [DATA_W-1:0] r_c_rdata;
  logic              r_d_ack;
  logic              r_d_err;
  logic [DATA_W-1:0] r_d_rdata;

  logic w_c_elig;
  logic w_d_elig;
  logic w_grant_c;
  logic w_grant_d;
  logic w_done;
  logic w_tmo;

  // A requester whose ack is high this cycle is still holding its old req, so skip it.
  assign w_c_elig = c_req & ~r_c_ack & ~d_lock;
  assign w_d_elig = d_req & ~r_d_ack;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_c   = 1'b0;
    w_grant_d   = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_c_elig && (!w_d_elig || r_last_owner)) begin
          w_grant_c   = 1'b1;
          w_state_nxt = CORE;
        end else if (w_d_elig) begin
          w_grant_d   = 1'b1;
          w_state_nxt = DBG;
        end
      end
      CORE, DBG: begin
        // m_ready takes precedence over a timeout landing in the same cycle.
        if (m_ready) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_cnt == CNT_MAX) begin
          w_tmo       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_owner <= 1'b1;
      r_cnt        <= '0;
      r_m_we       <= 1'b0;
      r_m_addr     <= '0;
      r_m_wdata    <= '0;
      r_c_ack      <= 1'b0;
      r_c_err      <= 1'b0;
      r_c_rdata    <= '0;
      r_d_ack      <= 1'b0;
      r_d_err      <= 1'b0;
      r_d_rdata    <= '0;
    end else begin
      r_c_ack <= 1'b0;
      r_c_err <= 1'b0;
      r_d_ack <= 1'b0;
      r_d_err <= 1'b0;
      if (w_grant_c || w_grant_d) begin
        r_last_owner <= w_grant_d;
        r_cnt        <= '0;
        r_m_we       <= w_grant_d ? d_we    : c_we;
        r_m_addr     <= w_grant_d ? d_addr  : c_addr;
        r_m_wdata    <= w_grant_d ? d_wdata : c_wdata;
      end
      if ((r_state != IDLE) && !m_ready && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_done || w_tmo) begin
        if (r_state == DBG) begin
          r_d_ack <= 1'b1;
          r_d_err <= w_tmo;
        end else begin
          r_c_ack <= 1'b1;
          r_c_err <= w_tmo;
        end
      end
      if (w_done) begin
        if (r_state == DBG) begin
          r_d_rdata <= m_rdata;
        end else begin
          r_c_rdata <= m_rdata;
        end
      end
    end
  end

  assign busy    = (r_state != IDLE);
  assign owner   = (r_state == DBG);
  assign m_req   = busy;
  assign m_we    = r_m_we;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;
  assign c_ack   = r_c_ack;
  assign c_err   = r_c_err;
  assign c_rdata = r_c_rdata;
  assign d_ack   = r_d_ack;
  assign d_err   = r_d_err;
  assign d_rdata = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed reset-mid-grant check, then random traffic from
// both requesters against a cycle-level reference model with a scoreboard per requester.
module tb_mem_port_arbiter;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        c_req = 1'b0, c_we = 1'b0;
  logic [31:0] c_addr = '0, c_wdata = '0;
  logic        d_req = 1'b0, d_we = 1'b0, d_lock = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [31:0] m_rdata = '0;
  logic        m_ready = 1'b0;
  logic        c_ack, c_err, d_ack, d_err, m_req, m_we, busy, owner;
  logic [31:0] c_rdata, d_rdata, m_addr, m_wdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit run = 0;
  bit stop = 0;

  logic [64:0] c_exp_q[$];
  logic [64:0] d_exp_q[$];
  logic [31:0] hold[2] = '{32'd0, 32'd0};
  logic [31:0] mem[16];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_err(c_err), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_lock(d_lock),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .busy(busy), .owner(owner)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] rand_addr();
    return {26'd0, 4'($urandom_range(0, 15)), 2'b00};
  endfunction

  function automatic void drive(input bit who, input logic req, input logic we,
                                input logic [31:0] a, input logic [31:0] wd);
    if (who) begin
      d_req = req; d_we = we; d_addr = a; d_wdata = wd;
    end else begin
      c_req = req; c_we = we; c_addr = a; c_wdata = wd;
    end
  endfunction

  function automatic void push(input bit who, input logic [64:0] v);
    if (who) d_exp_q.push_back(v);
    else     c_exp_q.push_back(v);
  endfunction

  // Memory wait states: mostly short, sometimes right at or past the timeout edge.
  function automatic int pick_wait();
    case ($urandom_range(0, 9))
      6:       return TO - 1;
      7:       return TO - 2;
      8, 9:    return TO + 3;
      default: return int'($urandom_range(0, 3));
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic req_drv(input bit who);
    int n;
    int k;
    logic we;
    logic [31:0] a, wd;
    @(posedge clk); #1;
    while (!stop) begin
      we = 1'($urandom_range(0, 1));
      a  = rand_addr();
      wd = $urandom;
      drive(who, 1'b1, we, a, wd);
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
        // Wiggle address/data while waiting; the captured access must not follow.
        if (!(who ? d_ack : c_ack) && $urandom_range(0, 5) == 0) begin
          a  = rand_addr();
          wd = $urandom;
          drive(who, 1'b1, we, a, wd);
        end
      end while (!(who ? d_ack : c_ack) && n < 400);
      chk(who ? "d_ack_bound" : "c_ack_bound", 128'(who ? d_ack : c_ack), 128'(1));
      k = int'($urandom_range(0, 2));
      if (k != 0) begin
        drive(who, 1'b0, we, a, wd);
        repeat (k) @(posedge clk);
        #1;
      end
    end
    drive(who, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic lock_drv();
    forever begin
      @(posedge clk); #1;
      if (stop) d_lock = 1'b0;
      else if ($urandom_range(0, 15) == 0) d_lock = ~d_lock;
    end
  endtask

  // ---------------- reference model + memory ----------------
  task automatic model_loop();
    bit          busy_m = 0, own = 0, last = 1, c_el, d_el;
    int          e = 0, w = 0, nxt;
    int          ack_at[2] = '{-10, -10};
    logic        we_m = 1'b0;
    logic [31:0] a_m = '0, wd_m = '0, rd;
    logic [31:0] rd_m[2] = '{32'd0, 32'd0};
    forever begin
      @(negedge clk);
      nxt = cyc + 1;
      chk("mreq", 128'({m_req, busy}), 128'({busy_m, busy_m}));
      if (busy_m)
        chk("mbus", 128'({owner, m_we, m_addr, m_wdata}), 128'({own, we_m, a_m, wd_m}));
      if (busy_m) begin
        if (e == w) begin
          rd = we_m ? wd_m : mem[a_m[5:2]];
          if (we_m) mem[a_m[5:2]] = wd_m;
          m_ready   = 1'b1;
          m_rdata   = rd;
          rd_m[own] = rd;
          push(own, {nxt, 1'b0, rd});
          ack_at[own] = nxt;
          busy_m = 0;
        end else begin
          m_ready = 1'b0;
          m_rdata = $urandom;
          if (e == TO - 1) begin
            push(own, {nxt, 1'b1, rd_m[own]});
            ack_at[own] = nxt;
            busy_m = 0;
          end else begin
            e++;
          end
        end
      end else begin
        m_ready = 1'($urandom_range(0, 1));
        m_rdata = $urandom;
        c_el = c_req && (ack_at[0] != cyc) && !d_lock;
        d_el = d_req && (ack_at[1] != cyc);
        if (c_el || d_el) begin
          own    = (c_el && d_el) ? !last : d_el;
          last   = own;
          we_m   = own ? d_we : c_we;
          a_m    = own ? d_addr : c_addr;
          wd_m   = own ? d_wdata : c_wdata;
          busy_m = 1;
          e      = 0;
          w      = pick_wait();
        end
      end
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  function automatic void mon(input bit who, input logic ack, input logic err, input logic [31:0] rd);
    logic [64:0] e;
    if (ack) begin
      if ((who ? d_exp_q.size() : c_exp_q.size()) == 0) begin
        chk(who ? "d_ack_unexpected" : "c_ack_unexpected", 128'(ack), 128'(0));
      end else begin
        e = who ? d_exp_q.pop_front() : c_exp_q.pop_front();
        chk(who ? "d_ack" : "c_ack", 128'({cyc, err, rd}), 128'(e));
        hold[who] = e[31:0];
      end
    end else begin
      chk(who ? "d_hold" : "c_hold", 128'({err, rd}), 128'({1'b0, hold[who]}));
    end
  endfunction

  initial begin
    wait (run);
    forever begin
      @(negedge clk);
      mon(1'b0, c_ack, c_err, c_rdata);
      mon(1'b1, d_ack, d_err, d_rdata);
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    repeat (3) @(negedge clk);
    chk("reset_out", 128'({m_req, m_we, busy, owner, c_ack, c_err, d_ack, d_err, m_addr, m_wdata, c_rdata}),
        128'(0));
    chk("reset_d_rdata", 128'(d_rdata), 128'(0));

    // Reset while a core grant is in flight.
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
    @(negedge clk);
    chk("rst_grant", 128'({m_req, busy, owner, m_we, m_addr}), 128'({4'b1100, 32'h40}));
    #2 rst = 1'b0;
    #1;
    chk("rst_async", 128'({m_req, m_we, busy, owner, c_ack, c_err, d_ack, d_err, m_addr, m_wdata, c_rdata}),
        128'(0));
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_ack", 128'({c_ack, m_req}), 128'(0));
    end
    m_ready = 1'b1;
    m_rdata = 32'h1234_5678;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_regrant", 128'({m_req, owner, m_addr}), 128'({2'b10, 32'h40}));
    @(negedge clk);
    chk("rst_served", 128'({c_ack, c_err, m_req, c_rdata}), 128'({3'b100, 32'h1234_5678}));
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    m_ready = 1'b0;

    // Clean reset, then random traffic.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run = 1;
    fork
      model_loop();
      lock_drv();
    join_none
    fork
      req_drv(1'b0);
      req_drv(1'b1);
      begin
        repeat (3000) @(negedge clk);
        stop = 1;
      end
    join
    repeat (40) @(negedge clk);
    chk("drain", 128'({c_exp_q.size(), d_exp_q.size()}), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
